// File: rtl/led_effect_sequencer.sv
// LED effect sequencer: four raw switches are synchronized and debounced into
// an effect code, and a prescaler paces one LED pattern step per tick.
// Accepting a new code restarts the prescaler and loads that effect's start
// pattern, so the first step of every effect always lasts one full period.
module led_effect_sequencer #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int DEB_CYCLES = 250_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  output logic [7:0] led,
  output logic [3:0] mode,
  output logic       tick
);

  localparam int PCNT_W = $clog2(TICK_DIV);
  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;

  logic [3:0]        r_sync1;
  logic [3:0]        r_sync2;
  logic [3:0]        r_cand;
  logic [DEB_W-1:0]  r_deb;
  logic [3:0]        r_mode;
  logic [PCNT_W-1:0] r_pcnt;
  logic              r_tick;
  logic [7:0]        r_led;
  dir_t              r_dir;

  logic              w_accept;
  logic              w_wrap;
  logic [7:0]        w_init_led;
  logic [7:0]        w_step_led;
  dir_t              w_step_dir;
  logic [7:0]        w_led_next;
  dir_t              w_dir_next;
  logic [PCNT_W-1:0] w_pcnt_next;
  logic              w_tick_next;

  // The candidate has been stable long enough and differs from the current mode.
  assign w_accept = (r_sync2 == r_cand) && (r_cand != r_mode) && (r_deb == DEB_LAST);
  assign w_wrap   = (r_pcnt == PCNT_LAST);

  // Start pattern of the effect about to be accepted (the candidate code).
  always_comb begin
    w_init_led = 8'h00;
    case (r_cand)
      4'd2:    w_init_led = 8'h01;
      4'd3:    w_init_led = 8'h80;
      4'd4:    w_init_led = 8'h01;
      4'd7:    w_init_led = 8'h55;
      default: w_init_led = 8'h00;
    endcase
  end

  // One pattern step of the current effect; ping-pong also updates its direction.
  always_comb begin
    w_step_led = 8'h00;
    w_step_dir = r_dir;
    case (r_mode)
      4'd1: w_step_led = ~r_led;
      4'd2: w_step_led = {r_led[6:0], r_led[7]};
      4'd3: w_step_led = {r_led[0], r_led[7:1]};
      4'd4: begin
        w_step_led = (r_dir == DIR_LEFT) ? {r_led[6:0], 1'b0} : {1'b0, r_led[7:1]};
        // Turn around on reaching an end so each endpoint is shown for one step.
        if (w_step_led == 8'h80) begin
          w_step_dir = DIR_RIGHT;
        end else if (w_step_led == 8'h01) begin
          w_step_dir = DIR_LEFT;
        end
      end
      4'd5:    w_step_led = (r_led == 8'hFF) ? 8'h00 : {r_led[6:0], 1'b1};
      4'd6:    w_step_led = r_led + 8'd1;
      4'd7:    w_step_led = ~r_led;
      default: w_step_led = 8'h00;
    endcase
  end

  // Next state for prescaler, LEDs and direction; a mode accept overrides a wrap.
  always_comb begin
    w_led_next  = r_led;
    w_dir_next  = r_dir;
    w_tick_next = 1'b0;
    w_pcnt_next = w_wrap ? '0 : r_pcnt + PCNT_W'(1);
    if (w_accept) begin
      w_led_next  = w_init_led;
      w_dir_next  = DIR_LEFT;
      w_pcnt_next = '0;
    end else if (w_wrap) begin
      w_led_next  = w_step_led;
      w_dir_next  = w_step_dir;
      w_tick_next = 1'b1;
    end
  end

  // Switch synchronizer and debounce; any change of the synchronized value restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
      r_cand  <= 4'd0;
      r_deb   <= '0;
      r_mode  <= 4'd0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_deb  <= '0;
      end else if (w_accept) begin
        r_mode <= r_cand;
        r_deb  <= '0;
      end else if (r_cand != r_mode) begin
        r_deb <= r_deb + DEB_W'(1);
      end
    end
  end

  // Prescaler, tick pulse, LED pattern and ping-pong direction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
      r_led  <= 8'h00;
      r_dir  <= DIR_LEFT;
    end else begin
      r_pcnt <= w_pcnt_next;
      r_tick <= w_tick_next;
      r_led  <= w_led_next;
      r_dir  <= w_dir_next;
    end
  end

  assign led  = r_led;
  assign mode = r_mode;
  assign tick = r_tick;

endmodule

// File: tb/tb_led_effect_sequencer.sv
// Bench for led_effect_sequencer with TICK_DIV = 4 and DEB_CYCLES = 3.
// A table of effect codes with their expected LED sequences drives most of the
// run; expected step values are queued when a mode is accepted and a monitor
// pops and compares them on every tick, also checking the tick period.
module tb_led_effect_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] sw;
  logic [7:0] led;
  logic [3:0] mode;
  logic       tick;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [3:0]         code;
    logic [0:8][7:0]    seq;   // start pattern then eight tick values
  } vec_t;

  vec_t tbl [7];
  logic [0:15][7:0] pp;

  led_effect_sequencer #(
    .TICK_DIV   (4),
    .DEB_CYCLES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .led   (led),
    .mode  (mode),
    .tick  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a new code and check the exact accept edge, start pattern and no tick.
  task automatic do_accept(input logic [3:0] code, input logic [3:0] old_code, input logic [7:0] init);
    sw = code;
    step(5);
    chk("mode_before_accept", {28'd0, mode}, {28'd0, old_code});
    step(1);
    chk("mode_accept", {28'd0, mode}, {28'd0, code});
    chk("accept_led", {24'd0, led}, {24'd0, init});
    chk("accept_tick", {31'd0, tick}, 32'd0);
  endtask

  // Wait (bounded) for the monitor to consume all queued tick expectations.
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: compares LEDs on each tick, checks tick spacing and no tick on accept.
  initial begin
    int cyc;
    int last_evt;
    bit after_rst;
    logic [3:0] prev_mode;
    logic [7:0] e;
    cyc = 0;
    last_evt = 0;
    after_rst = 1'b1;
    prev_mode = 4'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        after_rst = 1'b1;
        prev_mode = mode;
      end else if (mode != prev_mode) begin
        chk("no_tick_on_accept", {31'd0, tick}, 32'd0);
        last_evt = cyc;
        after_rst = 1'b0;
        prev_mode = mode;
      end else if (tick) begin
        if (!after_rst) begin
          chk("tick_period", cyc - last_evt, 32'd4);
        end
        after_rst = 1'b0;
        last_evt = cyc;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tick_led", {24'd0, led}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    logic [3:0] cur;
    bit found;

    tbl[0].code = 4'd2; tbl[0].seq = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    tbl[1].code = 4'd3; tbl[1].seq = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    tbl[2].code = 4'd1; tbl[2].seq = {8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    tbl[3].code = 4'd7; tbl[3].seq = {8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
    tbl[4].code = 4'd0; tbl[4].seq = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[5].code = 4'd9; tbl[5].seq = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[6].code = 4'd6; tbl[6].seq = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    pp = {8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
          8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

    reset = 1'b1;
    sw    = 4'd0;
    step(3);
    reset = 1'b0;
    chk("reset_led", {24'd0, led}, 32'd0);
    chk("reset_mode", {28'd0, mode}, 32'd0);
    chk("reset_tick", {31'd0, tick}, 32'd0);

    // Table-driven effects: accept each code, then eight queued tick values.
    cur = 4'd0;
    for (int i = 0; i < 7; i++) begin
      do_accept(tbl[i].code, cur, tbl[i].seq[0]);
      for (int k = 1; k < 9; k++) exp_q.push_back(tbl[i].seq[k]);
      $display("mode %0d: start %02h, 8 steps queued", tbl[i].code, tbl[i].seq[0]);
      drain("table_drain", 8 * 4 + 12);
      cur = tbl[i].code;
    end

    // Ping-pong over 16 ticks, covering both turnarounds.
    do_accept(4'd4, cur, 8'h01);
    for (int k = 0; k < 16; k++) exp_q.push_back(pp[k]);
    $display("mode 4: start 01, 16 steps queued");
    drain("pingpong_drain", 16 * 4 + 12);

    // Bounce 0->5->0->5 with 2-cycle dwell, then hold 5.
    do_accept(4'd0, 4'd4, 8'h00);
    sw = 4'd5;
    step(2);
    chk("bounce_hold_a", {28'd0, mode}, 32'd0);
    sw = 4'd0;
    step(2);
    chk("bounce_hold_b", {28'd0, mode}, 32'd0);
    do_accept(4'd5, 4'd0, 8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'h03); exp_q.push_back(8'h07);
    exp_q.push_back(8'h0F); exp_q.push_back(8'h1F); exp_q.push_back(8'h3F);
    exp_q.push_back(8'h7F); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    $display("mode 5: after bounce, 9 fill steps queued");
    drain("fill_drain", 9 * 4 + 12);

    // Count through a full 256-step wrap.
    do_accept(4'd6, 4'd5, 8'h00);
    for (int k = 1; k <= 256; k++) exp_q.push_back(8'(k));
    $display("mode 6: 256 count steps queued");
    drain("count_drain", 256 * 4 + 12);

    // Collision: land the accept of code 7 on a prescaler wrap edge.
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      step(1);
      if (tick) found = 1'b1;
    end
    chk("collision_find_tick", {31'd0, found}, 32'd1);
    step(2);
    do_accept(4'd7, 4'd6, 8'h55);
    exp_q.push_back(8'hAA);
    step(3);
    chk("collision_no_early_tick", {31'd0, tick}, 32'd0);
    step(1);
    chk("collision_next_tick", {31'd0, tick}, 32'd1);
    chk("collision_next_led", {24'd0, led}, 32'hAA);
    $display("collision: accept of 7 on wrap edge, next step AA");
    drain("collision_drain", 8);

    // Reserved code keeps ticking with LEDs off.
    do_accept(4'd9, 4'd7, 8'h00);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h00);
    $display("mode 9: reserved, 4 steps queued");
    drain("reserved_drain", 4 * 4 + 12);

    // Asynchronous reset in the middle of mode 6.
    do_accept(4'd6, 4'd9, 8'h00);
    step(8);
    chk("pre_reset_led", {24'd0, led}, 32'h02);
    reset = 1'b1;
    sw    = 4'd0;
    #1;
    chk("async_reset_led", {24'd0, led}, 32'd0);
    chk("async_reset_mode", {28'd0, mode}, 32'd0);
    chk("async_reset_tick", {31'd0, tick}, 32'd0);
    step(2);
    reset = 1'b0;
    step(3);
    chk("post_reset_no_tick", {31'd0, tick}, 32'd0);
    step(1);
    chk("post_reset_first_tick", {31'd0, tick}, 32'd1);
    chk("post_reset_led", {24'd0, led}, 32'd0);
    step(8);
    chk("post_reset_led_idle", {24'd0, led}, 32'd0);
    chk("post_reset_mode_idle", {28'd0, mode}, 32'd0);
    $display("reset: mid-run reset in mode 6, idle afterwards");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
